// File: rtl/koios_mem_pkg.sv
// Shared constants and helpers for the on-chip memory blocks.
package koios_mem_pkg;

  localparam int RDW_NO_CHANGE   = 0;
  localparam int RDW_READ_FIRST  = 1;
  localparam int RDW_WRITE_FIRST = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } clr_state_t;

  function automatic int nbytes(input int dwidth, input int bwidth);
    return dwidth / bwidth;
  endfunction

endpackage

// File: rtl/spram_core.sv
// Raw single-port array: per-lane write enables, registered read-first output.
module spram_core #(
  parameter int IWIDTH    = 10,
  parameter int NUM_WORDS = 1024,
  parameter int DWIDTH    = 32,
  parameter int BWIDTH    = 8,
  parameter int NBYTES    = 4
) (
  input  logic              clk,
  input  logic              en,
  input  logic [IWIDTH-1:0] addr,
  input  logic [NBYTES-1:0] we,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

`ifdef SIMULATION_MEMORY
  logic [DWIDTH-1:0] mem [NUM_WORDS];
`else
  (* ram_style = "block" *) logic [DWIDTH-1:0] mem [NUM_WORDS];
`endif

  // Read returns the pre-write contents; the top derives write-first data from it.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < NBYTES; i++) begin
        if (we[i]) mem[addr][i*BWIDTH +: BWIDTH] <= wdata[i*BWIDTH +: BWIDTH];
      end
    end
  end

endmodule

// File: rtl/spram_be_pipe.sv
// Byte-enabled single-port RAM with RDW selection, optional output register,
// request/response valids and a post-reset zero-clear sweep.
module spram_be_pipe
  import koios_mem_pkg::*;
#(
  parameter int AWIDTH         = 10,
  parameter int NUM_WORDS      = 1024,
  parameter int DWIDTH         = 32,
  parameter int BWIDTH         = 8,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NBYTES        = nbytes(DWIDTH, BWIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [AWIDTH-1:0] address,
  input  logic              wren,
  input  logic [NBYTES-1:0] be,
  input  logic [DWIDTH-1:0] data,
  output logic [DWIDTH-1:0] out,
  output logic              out_valid,
  output logic              busy
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [AWIDTH:0] DEPTH    = (AWIDTH+1)'(NUM_WORDS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_WORDS - 1);

  function automatic logic [DWIDTH-1:0] merge_lanes(input logic [DWIDTH-1:0] old_w,
                                                    input logic [DWIDTH-1:0] new_w,
                                                    input logic [NBYTES-1:0] lane_en);
    logic [DWIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane_en[i]) r[i*BWIDTH +: BWIDTH] = new_w[i*BWIDTH +: BWIDTH];
    end
    return r;
  endfunction

  clr_state_t        state_q, state_d;
  logic [IW-1:0]     clr_cnt;
  logic              busy_i, clearing, accept, in_range, resp_req;
  logic              core_en;
  logic [IW-1:0]     core_addr;
  logic [NBYTES-1:0] core_we;
  logic [DWIDTH-1:0] core_wdata, core_rdata;
  logic              vld_p0, wr_p0, oor_p0;
  logic [DWIDTH-1:0] wdata_p0, resp_p0;
  logic [NBYTES-1:0] be_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (clearing) clr_cnt <= clr_cnt + IW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      CLEAR:   if (clr_cnt == LAST_IDX) state_d = READY;
      default: state_d = state_q;
    endcase
  end

  assign busy_i   = (state_q != READY);
  assign clearing = (state_q == CLEAR) && !reset;
  assign accept   = req_valid & ~busy_i & ~reset;
  assign in_range = {1'b0, address} < DEPTH;
  assign resp_req = accept & (~wren | (RDW_MODE != RDW_NO_CHANGE));

  // Clear sweep owns the port while active; user requests cannot be accepted then.
  always_comb begin
    core_en    = clearing | (accept & in_range);
    core_addr  = clearing ? clr_cnt : address[IW-1:0];
    core_we    = clearing ? '1 : ({NBYTES{accept & wren & in_range}} & be);
    core_wdata = clearing ? '0 : data;
  end

  spram_core #(
    .IWIDTH   (IW),
    .NUM_WORDS(NUM_WORDS),
    .DWIDTH   (DWIDTH),
    .BWIDTH   (BWIDTH),
    .NBYTES   (NBYTES)
  ) u_core (
    .clk  (clk),
    .en   (core_en),
    .addr (core_addr),
    .we   (core_we),
    .wdata(core_wdata),
    .rdata(core_rdata)
  );

  // ---- stage p0: array output available ----
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= resp_req;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0    <= wren;
      oor_p0   <= ~in_range;
      wdata_p0 <= data;
      be_p0    <= be;
    end
  end

  always_comb begin
    resp_p0 = core_rdata;
    if (oor_p0)                                  resp_p0 = '0;
    else if (wr_p0 && RDW_MODE == RDW_WRITE_FIRST) resp_p0 = merge_lanes(core_rdata, wdata_p0, be_p0);
  end

  // ---- stage p1: optional output register ----
  if (OUT_REG != 0) begin : g_out_reg
    logic [DWIDTH-1:0] out_p1;
    logic              vld_p1;
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p1 <= 1'b0;
        out_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) out_p1 <= resp_p0;
      end
    end
    assign out       = out_p1;
    assign out_valid = vld_p1;
  end else begin : g_out_comb
    logic [DWIDTH-1:0] out_hold;
    always_ff @(posedge clk) begin
      if (reset)       out_hold <= '0;
      else if (vld_p0) out_hold <= resp_p0;
    end
    assign out       = vld_p0 ? resp_p0 : out_hold;
    assign out_valid = vld_p0;
  end

  assign busy = busy_i;

endmodule

// File: tb/tb_spram_be_pipe.sv
// Scoreboard bench: three RAM configurations driven by one request stream,
// each checked against a word-array reference model.
module tb_spram_be_pipe;

  localparam int AW_P  [3] = '{4, 5, 4};
  localparam int NW_P  [3] = '{12, 16, 16};
  localparam int RDW_P [3] = '{1, 2, 0};
  localparam int OR_P  [3] = '{0, 1, 0};
  localparam int CLR_P [3] = '{1, 1, 0};
  localparam int NEVER = 32'h7fffffff;

  typedef struct {
    logic [31:0] d;
    int          due;
    bit          dc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst, rv, wr;
  logic [4:0]  ad;
  logic [3:0]  bes;
  logic [31:0] dt;
  logic [31:0] q_o    [3];
  logic        qv_o   [3];
  logic        busy_o [3];

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  rsp_t        expq [3][$];
  logic [31:0] mm [3][32];
  bit          kn [3][32];
  int          ready_c [3];
  logic [31:0] last_out [3];
  rsp_t        mon_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spram_be_pipe #(.AWIDTH(4), .NUM_WORDS(12), .DWIDTH(32), .BWIDTH(8),
                  .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .reset(rst), .req_valid(rv), .address(ad[3:0]), .wren(wr), .be(bes),
    .data(dt), .out(q_o[0]), .out_valid(qv_o[0]), .busy(busy_o[0]));

  spram_be_pipe #(.AWIDTH(5), .NUM_WORDS(16), .DWIDTH(32), .BWIDTH(8),
                  .RDW_MODE(2), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset(rst), .req_valid(rv), .address(ad), .wren(wr), .be(bes),
    .data(dt), .out(q_o[1]), .out_valid(qv_o[1]), .busy(busy_o[1]));

  spram_be_pipe #(.AWIDTH(4), .NUM_WORDS(16), .DWIDTH(32), .BWIDTH(8),
                  .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .reset(rst), .req_valid(rv), .address(ad[3:0]), .wren(wr), .be(bes),
    .data(dt), .out(q_o[2]), .out_valid(qv_o[2]), .busy(busy_o[2]));

  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  // Reference behaviour of one configuration for the request currently on the bus.
  function automatic void model(input int k);
    int          a;
    bit          inr, kn_old;
    logic [31:0] old, nw, m;
    rsp_t        r;
    if (!rv || rst || cyc < ready_c[k]) return;
    a     = int'(ad) % (1 << AW_P[k]);
    inr   = (a < NW_P[k]);
    r.due = cyc + 1 + OR_P[k];
    if (wr) begin
      m      = lane_mask(bes);
      old    = inr ? mm[k][a] : 32'h0;
      nw     = (old & ~m) | (dt & m);
      kn_old = kn[k][a];
      if (inr) begin
        mm[k][a] = nw;
        kn[k][a] = kn[k][a] | (bes == 4'hF);
      end
      if (RDW_P[k] == 1) begin
        r.d = old; r.dc = inr && !kn_old;
        expq[k].push_back(r);
      end else if (RDW_P[k] == 2) begin
        r.d = inr ? nw : 32'h0; r.dc = inr && !kn[k][a];
        expq[k].push_back(r);
      end
    end else begin
      r.d  = inr ? mm[k][a] : 32'h0;
      r.dc = inr && !kn[k][a];
      expq[k].push_back(r);
    end
  endfunction

  task check_busy;
    logic exp_b;
    for (int k = 0; k < 3; k++) begin
      exp_b = (cyc < ready_c[k]);
      total++;
      if (busy_o[k] !== exp_b) begin
        bad++;
        $display("FAIL busy inst=%0d cyc=%0d got=%b want=%b", k, cyc, busy_o[k], exp_b);
      end
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
    check_busy();
  endtask

  task drive(input bit v, input bit w, input logic [4:0] a, input logic [3:0] b,
             input logic [31:0] d);
    rv = v; wr = w; ad = a; bes = b; dt = d;
    for (int k = 0; k < 3; k++) model(k);
    tick();
  endtask

  task rnd;
    drive(bit'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom),
          4'($urandom), $urandom);
  endtask

  task idle;
    drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
  endtask

  task set_reset(input bit v);
    rsp_t keep [$];
    rst = v;
    for (int k = 0; k < 3; k++) begin
      if (v) begin
        ready_c[k] = (CLR_P[k] != 0) ? NEVER : 0;
        keep = {};
        foreach (expq[k][i]) if (expq[k][i].due <= cyc) keep.push_back(expq[k][i]);
        expq[k] = keep;
      end else if (CLR_P[k] != 0) begin
        ready_c[k] = cyc + NW_P[k];
        for (int a = 0; a < NW_P[k]; a++) begin
          mm[k][a] = 32'h0;
          kn[k][a] = 1'b1;
        end
      end
    end
  endtask

  task sweep_reads;
    for (int a = 0; a < 32; a++) drive(1'b1, 1'b0, 5'(a), 4'h0, 32'h0);
  endtask

  // Monitor: pops one expectation per out_valid pulse; otherwise out must hold.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      while (expq[k].size() > 0 && expq[k][0].due < cyc) begin
        total++; bad++;
        $display("FAIL missing_rsp inst=%0d cyc=%0d got=no_valid want_due=%0d want=%h",
                 k, cyc, expq[k][0].due, expq[k][0].d);
        expq[k].delete(0);
      end
      if (qv_o[k] === 1'b1) begin
        total++;
        if (expq[k].size() == 0) begin
          bad++;
          $display("FAIL spurious_valid inst=%0d cyc=%0d got=%h want=no_valid", k, cyc, q_o[k]);
          last_out[k] = q_o[k];
        end else begin
          mon_r = expq[k].pop_front();
          if (mon_r.due != cyc || (!mon_r.dc && q_o[k] !== mon_r.d)) begin
            bad++;
            $display("FAIL rsp inst=%0d cyc=%0d got=%h want=%h (due=%0d)",
                     k, cyc, q_o[k], mon_r.d, mon_r.due);
          end
          last_out[k] = mon_r.dc ? q_o[k] : mon_r.d;
        end
      end else if (rst) begin
        last_out[k] = 32'h0;
      end else begin
        total++;
        if (q_o[k] !== last_out[k] || qv_o[k] !== 1'b0) begin
          bad++;
          $display("FAIL hold inst=%0d cyc=%0d got=%h/%b want=%h/0",
                   k, cyc, q_o[k], qv_o[k], last_out[k]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rv = 1'b0; wr = 1'b0; ad = '0; bes = '0; dt = '0;
    for (int k = 0; k < 3; k++) begin
      ready_c[k]  = (CLR_P[k] != 0) ? NEVER : 0;
      last_out[k] = 32'h0;
      for (int a = 0; a < 32; a++) begin
        kn[k][a] = 1'b0;
        mm[k][a] = 32'h0;
      end
    end
    repeat (3) tick();
    set_reset(1'b0);

    // Writes while clearing are ignored by cleared configs, accepted by the uncleared one.
    repeat (20) drive(1'b1, 1'b1, 5'($urandom), 4'($urandom), $urandom);
    sweep_reads();

    // Byte lanes on addr 5
    drive(1'b1, 1'b1, 5'd5, 4'hF, 32'hAABBCCDD);
    drive(1'b1, 1'b1, 5'd5, 4'h5, 32'h11223344);
    drive(1'b1, 1'b0, 5'd5, 4'h0, 32'h0);
    // Read-during-write on addr 3
    drive(1'b1, 1'b1, 5'd3, 4'hF, 32'h12345678);
    drive(1'b1, 1'b1, 5'd3, 4'hF, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 5'd3, 4'h0, 32'h0);
    // Back-to-back preload and read of 0..7
    for (int a = 0; a < 8; a++) drive(1'b1, 1'b1, 5'(a), 4'hF, 32'h100 + 32'(a));
    for (int a = 0; a < 8; a++) drive(1'b1, 1'b0, 5'(a), 4'h0, 32'h0);
    // Out-of-range write/read and alias check
    drive(1'b1, 1'b1, 5'd13, 4'hF, 32'hFFFFFFFF);
    drive(1'b1, 1'b0, 5'd13, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 5'd1, 4'h0, 32'h0);
    // Alternating write/read of one address
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'd9, 4'($urandom), $urandom);
      drive(1'b1, 1'b0, 5'd9, 4'h0, 32'h0);
    end
    repeat (400) rnd();

    // Reset landing mid-sweep at clear counter 9
    set_reset(1'b1);
    repeat (2) rnd();
    set_reset(1'b0);
    repeat (9) rnd();
    set_reset(1'b1);
    repeat (2) rnd();
    set_reset(1'b0);
    repeat (18) rnd();
    sweep_reads();
    repeat (300) rnd();
    repeat (5) idle();

    for (int k = 0; k < 3; k++) begin
      total++;
      if (expq[k].size() != 0) begin
        bad++;
        $display("FAIL leftover inst=%0d got=%0d pending want=0", k, expq[k].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spram_be_pipe.md
# spram_be_pipe

Parametrised single-port RAM successor with byte-lane write enables, selectable read-during-write behaviour, an optional output pipeline register, valid-qualified requests and a post-reset zero-clear sequencer. It is a drop-in on-chip buffer for weight, activation and scratch storage in the accelerator datapaths. It also replaces bare always-on RAM instances wherever consumers need a known-clean memory and an explicit read-data valid.

## Interface
- AWIDTH, 10, address width
- NUM_WORDS, 1024, depth in words; must be ≤ 2**AWIDTH
- DWIDTH, 32, data width; must be a multiple of BWIDTH
- BWIDTH, 8, byte-lane width; NBYTES = DWIDTH/BWIDTH
- RDW_MODE, 0, read-during-write: 0 NO_CHANGE, 1 READ_FIRST, 2 WRITE_FIRST
- OUT_REG, 0, 1 adds an output pipeline register
- CLEAR_ON_RESET, 1, 1 zero-fills the array after reset
- clk  input  1  single clock, all logic on posedge
- reset  input  1  synchronous, active-high
- req_valid  input  1  request strobe
- address  input  AWIDTH  word address
- wren  input  1  1 = write, 0 = read
- be  input  NBYTES  byte-lane write enables, lane i = data[i*BWIDTH +: BWIDTH]
- data  input  DWIDTH  write data
- out  output  DWIDTH  read data
- out_valid  output  1  out carries the response to an accepted request
- busy  output  1  clear in progress; requests are ignored

## Operation
- Accepted request: req_valid & ~busy & ~reset. Non-accepted requests have no effect and produce no out_valid.
- Write (wren=1): only lanes with be[i]=1 are updated; be=0 is a no-op write. A write produces out_valid=1 only in READ_FIRST and WRITE_FIRST modes:
  - READ_FIRST: out = old word.
  - WRITE_FIRST: out = merged new word, with the old value on disabled lanes.
  - NO_CHANGE: out holds its last value and out_valid=0.
- Read (wren=0): out = mem[address], out_valid=1. be is ignored.
- Out-of-range address (≥ NUM_WORDS): writes are dropped; reads return 0 with out_valid=1.
- out holds its value between responses. out_valid is a 1-cycle pulse per response.
- Clear FSM states are IDLE, CLEAR and READY.
  - reset forces CLEAR when CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR writes 0 to addresses 0..NUM_WORDS-1, one per cycle, then goes to READY.
  - READY is terminal until the next reset.
  - IDLE is the transient reset state.
- Reset asserted during CLEAR restarts the sweep at address 0.

## Timing
- Reset values: out=0, out_valid=0, busy=CLEAR_ON_RESET, clear counter=0. In-flight pipeline responses are discarded.
- Read latency = 1 + OUT_REG cycles, from the accepting edge to out/out_valid.
- Full throughput: one request per cycle, no bubbles, including alternating read/write to the same address.
- Write then read of the same address on the next cycle returns the written data (no hazard).
- Clear: busy deasserts exactly NUM_WORDS cycles after the first cycle with reset low. The first request is accepted that cycle.
- busy=1 guarantees out_valid=0, apart from responses already in the OUT_REG stage (none after reset).

## Structure
- Shared package koios_mem_pkg holds:
  - RDW_NO_CHANGE/RDW_READ_FIRST/RDW_WRITE_FIRST constants
  - FSM state encodings (IDLE=0, CLEAR=1, READY=2)
  - a function for NBYTES.
- One sub-module, spram_core: the raw array with per-lane write enables and registered read. Synthesis maps it to block RAM; under SIMULATION_MEMORY it is a behavioural array.
- The top level contains the clear FSM/counter, request muxing (clear has priority), the RDW merge, range check, optional output stage and the valid pipeline.

## Test plan
- Clear sweep: NUM_WORDS=16, CLEAR_ON_RESET=1; deassert reset → busy=1 for exactly 16 cycles; then reading every address returns 0x00000000 with out_valid 1 cycle after each request.
- Byte enables: write 0xAABBCCDD be=4'b1111 to addr 5, then write 0x11223344 be=4'b0101 → read addr 5 returns 0xAA22CC44.
- RDW modes: addr 3 holds 0x12345678; write 0xDEADBEEF be=all.
  - READ_FIRST → out=0x12345678, out_valid=1.
  - WRITE_FIRST → out=0xDEADBEEF.
  - NO_CHANGE → out unchanged, out_valid=0.
- Pipeline/throughput: OUT_REG=1, back-to-back reads of addrs 0..7 (preloaded 0x100+a) → out_valid high for 8 consecutive cycles starting 2 cycles after the first request, data 0x100..0x107 in order.
- Reset mid-operation: assert reset at clear counter=9 → busy remains 1 and the sweep restarts, busy dropping 16 cycles after reset deasserts. Requests issued while busy produce no out_valid and do not corrupt memory.
- Range: NUM_WORDS=12, AWIDTH=4; write 0xFFFFFFFF to addr 13, then read addr 13 → out=0, out_valid=1. Read addr 1 (if 1 = 13 mod 12 aliasing were wrong) → 0.
